// File: rtl/fetch_queue_if.sv
// Fetch queue bundle: core redirect, instruction-memory request/response and
// the decoded-instruction handshake towards the core.
interface fetch_queue_if;
   logic        redirect;
   logic [31:0] redirect_addr;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;
   logic [31:0] inst_pc4;

   modport master (
      input  redirect, redirect_addr, imem_req_ready, imem_resp_valid,
             imem_resp_data, inst_ready,
      output imem_req_valid, imem_req_addr, inst_valid, inst_data,
             inst_pc, inst_pc4
   );

   modport slave (
      output redirect, redirect_addr, imem_req_ready, imem_resp_valid,
             imem_resp_data, inst_ready,
      input  imem_req_valid, imem_req_addr, inst_valid, inst_data,
             inst_pc, inst_pc4
   );
endinterface

// File: rtl/fetch_queue.sv
// Sequential instruction fetch with one outstanding memory request and a
// DEPTH-entry {instruction, pc} queue. Optional counters: FETCH_QUEUE_PERF_EN.
module fetch_queue #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input logic           clk,
   input logic           rst,
   fetch_queue_if.master bus
`ifdef FETCH_QUEUE_PERF_EN
   ,
   output logic [15:0]   flush_count,
   output logic [15:0]   stall_count
`endif
);
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

   state_t            state_q, state_d;
   logic [31:0]       fetch_pc_q, fetch_pc_d;
   logic [31:0]       req_pc_q, req_pc_d;
   logic [CNT_W-1:0]  count_q, count_d, count_after;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [31:0]       data_q [DEPTH];
   logic [31:0]       pc_q   [DEPTH];
   logic              accept, resp, push, pop, head_valid;

   assign head_valid = (count_q != '0);

   always_comb begin
      accept      = (state_q == REQ) && bus.imem_req_ready;
      resp        = bus.imem_resp_valid;
      push        = (state_q == WAIT) && resp && !bus.redirect;
      pop         = head_valid && bus.inst_ready && !bus.redirect;
      count_after = count_q + CNT_W'(push) - CNT_W'(pop);
      state_d     = state_q;
      fetch_pc_d  = fetch_pc_q;
      req_pc_d    = req_pc_q;
      count_d     = count_after;
      rd_ptr_d    = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      wr_ptr_d    = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;

      case (state_q)
         IDLE: if (count_q < FULL) state_d = REQ;
         REQ: begin
            if (accept) begin
               req_pc_d   = fetch_pc_q;
               fetch_pc_d = fetch_pc_q + 32'd4;
               state_d    = WAIT;
            end
         end
         WAIT: if (resp) state_d = (count_after < FULL) ? REQ : IDLE;
         DROP: if (resp) state_d = REQ;
         default: state_d = IDLE;
      endcase

      // A redirect wins over everything; a request still in flight must be
      // swallowed in DROP so its response never lands in the queue.
      if (bus.redirect) begin
         count_d    = '0;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         fetch_pc_d = {bus.redirect_addr[31:2], 2'b00};
         case (state_q)
            WAIT:    state_d = resp ? REQ : DROP;
            REQ:     state_d = accept ? DROP : REQ;
            DROP:    state_d = resp ? REQ : DROP;
            default: state_d = REQ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         fetch_pc_q <= RESET_PC;
         req_pc_q   <= '0;
         count_q    <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         req_pc_q   <= req_pc_d;
         count_q    <= count_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         data_q[wr_ptr_q] <= bus.imem_resp_data;
         pc_q[wr_ptr_q]   <= req_pc_q;
      end
   end

   assign bus.imem_req_valid = (state_q == REQ);
   assign bus.imem_req_addr  = fetch_pc_q;
   assign bus.inst_valid     = head_valid;
   // Storage is not reset, so the head is zeroed whenever the queue is empty.
   assign bus.inst_data      = head_valid ? data_q[rd_ptr_q] : '0;
   assign bus.inst_pc        = head_valid ? pc_q[rd_ptr_q] : '0;
   assign bus.inst_pc4       = head_valid ? pc_q[rd_ptr_q] + 32'd4 : '0;

`ifdef FETCH_QUEUE_PERF_EN
   logic [15:0] flush_count_q, flush_count_d;
   logic [15:0] stall_count_q, stall_count_d;

   function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
      return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
   endfunction

   // In DROP the stale response was already charged to the earlier redirect.
   always_comb begin
      flush_count_d = sat_inc(flush_count_q,
                              bus.redirect && (head_valid || (state_q == WAIT) || accept));
      stall_count_d = sat_inc(stall_count_q, bus.inst_ready && !head_valid);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flush_count_q <= '0;
         stall_count_q <= '0;
      end else begin
         flush_count_q <= flush_count_d;
         stall_count_q <= stall_count_d;
      end
   end

   assign flush_count = flush_count_q;
   assign stall_count = stall_count_q;
`endif
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: a queue-level reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_fetch_queue;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fetch_queue_if bus ();
   fetch_queue_if bus1 ();

`ifdef FETCH_QUEUE_PERF_EN
   logic [15:0] flush_count, stall_count, flush1, stall1;
`endif

   fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .rst(rst), .bus(bus)
`ifdef FETCH_QUEUE_PERF_EN
      , .flush_count(flush_count), .stall_count(stall_count)
`endif
   );

   fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) dut1 (
      .clk(clk), .rst(rst), .bus(bus1)
`ifdef FETCH_QUEUE_PERF_EN
      , .flush_count(flush1), .stall_count(stall1)
`endif
   );

   int tests = 0;
   int fails = 0;

   function automatic logic [31:0] memf(input logic [31:0] a);
      return a ^ 32'hA5A5_0000;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Memory responder state and logs for the main DUT, owned by step().
   int          mem_lat = 1;
   logic        pend = 1'b0;
   int          pcnt = 0;
   logic [31:0] paddr = 32'h0;
   logic        last_acc = 1'b0;
   logic [31:0] acc_log[$];
   logic [31:0] pop_log[$];
   logic [31:0] pc4_log[$];
   logic [31:0] dat_log[$];
   logic [31:0] acc1_log[$];
   logic [31:0] pop1_pc[$];
   logic [31:0] pop1_pc4[$];

   task automatic step();
      logic        acc;
      logic [31:0] a;
      @(negedge clk);
      acc = bus.imem_req_valid && bus.imem_req_ready && !rst;
      a   = bus.imem_req_addr;
      if (acc) acc_log.push_back(a);
      if (bus.inst_valid && bus.inst_ready && !bus.redirect && !rst) begin
         pop_log.push_back(bus.inst_pc);
         pc4_log.push_back(bus.inst_pc4);
         dat_log.push_back(bus.inst_data);
      end
      last_acc = acc;
      @(posedge clk);
      #1;
      bus.imem_resp_valid = 1'b0;
      if (rst) begin
         pend = 1'b0;
      end else if (acc) begin
         if (mem_lat <= 1) begin
            bus.imem_resp_valid = 1'b1;
            bus.imem_resp_data  = memf(a);
         end else begin
            pend  = 1'b1;
            pcnt  = mem_lat - 1;
            paddr = a;
         end
      end else if (pend) begin
         pcnt--;
         if (pcnt == 0) begin
            bus.imem_resp_valid = 1'b1;
            bus.imem_resp_data  = memf(paddr);
            pend = 1'b0;
         end
      end
   endtask

   task automatic do_reset(input logic rdy);
      rst = 1'b1;
      bus.inst_ready = rdy;
      bus.redirect = 1'b0;
      bus.imem_req_ready = 1'b1;
      mem_lat = 1;
      repeat (2) step();
      chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
      chk("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
      chk("rst_inst_data", bus.inst_data, 32'h0);
      chk("rst_inst_pc", bus.inst_pc, 32'h0);
      chk("rst_inst_pc4", bus.inst_pc4, 32'h0);
      rst = 1'b0;
      acc_log.delete(); pop_log.delete(); pc4_log.delete(); dat_log.delete();
   endtask

   // Reference model: outstanding requests tagged with a redirect epoch,
   // and the instruction queue as a plain queue of {pc, data}.
   typedef struct packed { logic [31:0] pc; logic [31:0] ep; } req_t;
   typedef struct packed { logic [31:0] pc; logic [31:0] data; } ent_t;

   initial begin
      req_t        oq[$];
      ent_t        mq[$];
      req_t        r;
      logic [31:0] epoch, exp_req;
      logic [15:0] flush_m, stall_m;
      logic        acc, rsp, pop, rd, stale_push;
      epoch = 0; exp_req = 0; flush_m = 0; stall_m = 0; r = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            oq.delete(); mq.delete();
            epoch = 0; exp_req = 32'h0; flush_m = 0; stall_m = 0;
         end else begin
            chk("m_inst_valid", 32'(bus.inst_valid), 32'(mq.size() != 0));
            if (mq.size() != 0) begin
               chk("m_inst_pc", bus.inst_pc, mq[0].pc);
               chk("m_inst_data", bus.inst_data, mq[0].data);
               chk("m_inst_pc4", bus.inst_pc4, mq[0].pc + 32'd4);
            end
            if (bus.imem_req_valid) chk("m_req_addr", bus.imem_req_addr, exp_req);
`ifdef FETCH_QUEUE_PERF_EN
            chk("m_flush_count", 32'(flush_count), 32'(flush_m));
            chk("m_stall_count", 32'(stall_count), 32'(stall_m));
`endif
            acc = bus.imem_req_valid && bus.imem_req_ready;
            rsp = bus.imem_resp_valid;
            pop = bus.inst_valid && bus.inst_ready;
            rd  = bus.redirect;
            if (rd && (mq.size() != 0 || (oq.size() != 0 && oq[0].ep == epoch) || acc)
                && flush_m != 16'hFFFF) flush_m++;
            if (bus.inst_ready && mq.size() == 0 && stall_m != 16'hFFFF) stall_m++;
            stale_push = 1'b0;
            if (rsp && oq.size() != 0) begin
               r = oq.pop_front();
               stale_push = !rd && (r.ep == epoch);
            end
            if (pop && !rd && mq.size() != 0) void'(mq.pop_front());
            if (stale_push) mq.push_back('{pc: r.pc, data: bus.imem_resp_data});
            if (acc) begin
               chk("m_one_outstanding", 32'(oq.size()), 32'd0);
               oq.push_back('{pc: bus.imem_req_addr, ep: epoch});
            end
            if (rd) begin
               mq.delete();
               epoch++;
               exp_req = {bus.redirect_addr[31:2], 2'b00};
            end else if (acc) begin
               exp_req = exp_req + 32'd4;
            end
         end
      end
   end

   // Second instance with a RESET_PC just below the wrap point.
   initial begin
      logic        acc1;
      logic [31:0] a1;
      bus1.redirect = 1'b0; bus1.redirect_addr = 32'h0;
      bus1.imem_req_ready = 1'b1; bus1.inst_ready = 1'b1;
      bus1.imem_resp_valid = 1'b0; bus1.imem_resp_data = 32'h0;
      forever begin
         @(negedge clk);
         acc1 = bus1.imem_req_valid && bus1.imem_req_ready && !rst;
         a1   = bus1.imem_req_addr;
         if (acc1) acc1_log.push_back(a1);
         if (bus1.inst_valid && bus1.inst_ready && !rst) begin
            pop1_pc.push_back(bus1.inst_pc);
            pop1_pc4.push_back(bus1.inst_pc4);
         end
         @(posedge clk);
         #1;
         bus1.imem_resp_valid = acc1 && !rst;
         bus1.imem_resp_data  = memf(a1);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
      $fatal(1);
   end

   initial begin
      int n;
      int n0;
      int p0;
      bus.redirect = 1'b0; bus.redirect_addr = 32'h0;
      bus.imem_req_ready = 1'b1; bus.inst_ready = 1'b1;
      bus.imem_resp_valid = 1'b0; bus.imem_resp_data = 32'h0;

      // Sequential fetch with 1-cycle memory, request held while not ready.
      do_reset(1'b1);
      bus.imem_req_ready = 1'b0;
      repeat (4) step();
      chk("hold_req_valid", 32'(bus.imem_req_valid), 32'd1);
      chk("hold_req_addr", bus.imem_req_addr, 32'h0);
      bus.imem_req_ready = 1'b1;
      repeat (12) step();
      chk("t1_req0", acc_log[0], 32'h0);
      chk("t1_req1", acc_log[1], 32'h4);
      chk("t1_req2", acc_log[2], 32'h8);
      chk("t1_pc0", pop_log[0], 32'h0);
      chk("t1_pc1", pop_log[1], 32'h4);
      chk("t1_pc2", pop_log[2], 32'h8);
      chk("t1_data0", dat_log[0], 32'hA5A5_0000);
      chk("t1_data2", dat_log[2], 32'hA5A5_0008);
      chk("t1_pc4_0", pc4_log[0], 32'h4);
      chk("t1_pc4_1", pc4_log[1], 32'h8);
      chk("t1_pc4_2", pc4_log[2], 32'hC);
      chk("wrap_req0", acc1_log[0], 32'hFFFF_FFF8);
      chk("wrap_req1", acc1_log[1], 32'hFFFF_FFFC);
      chk("wrap_req2", acc1_log[2], 32'h0);
      chk("wrap_pc1", pop1_pc[1], 32'hFFFF_FFFC);
      chk("wrap_pc4_1", pop1_pc4[1], 32'h0);

      // Core stalled: queue fills to DEPTH and fetch stops.
      do_reset(1'b0);
      repeat (20) step();
      chk("fill_pushes", 32'(acc_log.size()), 32'd4);
      chk("fill_req_idle", 32'(bus.imem_req_valid), 32'd0);
      chk("fill_inst_valid", 32'(bus.inst_valid), 32'd1);
      bus.inst_ready = 1'b1;
      repeat (20) step();
      chk("drain_pc0", pop_log[0], 32'h0);
      chk("drain_pc1", pop_log[1], 32'h4);
      chk("drain_pc2", pop_log[2], 32'h8);
      chk("drain_pc3", pop_log[3], 32'hC);
      chk("resume_addr", acc_log[4], 32'h10);

      // Redirect while waiting on a slow response.
      do_reset(1'b1);
      mem_lat = 4;
      n = 0;
      while (!last_acc && n < 20) begin step(); n++; end
      chk("t3_got_accept", 32'(last_acc), 32'd1);
      bus.redirect = 1'b1; bus.redirect_addr = 32'h0000_0103;
      step();
      bus.redirect = 1'b0;
      chk("t3_no_req_in_drop", 32'(bus.imem_req_valid), 32'd0);
      repeat (30) step();
      chk("t3_next_req", acc_log[1], 32'h100);
      chk("t3_first_pc", pop_log[0], 32'h100);
      chk("t3_first_data", dat_log[0], 32'hA5A5_0100);
      mem_lat = 1;

      // Redirect coinciding with a pop and a response.
      do_reset(1'b0);
      repeat (10) step();
      bus.inst_ready = 1'b1;
      n = 0;
      while (!(bus.imem_resp_valid && bus.inst_valid) && n < 20) begin step(); n++; end
      chk("t4_found_overlap", 32'(bus.imem_resp_valid && bus.inst_valid), 32'd1);
      n0 = acc_log.size();
      p0 = pop_log.size();
      bus.redirect = 1'b1; bus.redirect_addr = 32'h0000_0200;
      step();
      bus.redirect = 1'b0;
      chk("t4_empty_after", 32'(bus.inst_valid), 32'd0);
      repeat (10) step();
      chk("t4_next_req", acc_log[n0], 32'h200);
      chk("t4_first_pc", pop_log[p0], 32'h200);

`ifdef FETCH_QUEUE_PERF_EN
      // Three flushing redirects, one non-flushing, then five starved cycles.
      do_reset(1'b0);
      bus.redirect = 1'b1; bus.redirect_addr = 32'h40;
      step();
      bus.redirect = 1'b0;
      chk("perf_idle_redirect", 32'(flush_count), 32'd0);
      repeat (12) step();
      chk("perf_full", 32'(bus.inst_valid), 32'd1);
      bus.redirect = 1'b1; bus.redirect_addr = 32'h80;
      step();
      bus.redirect = 1'b0;
      n = 0;
      while (!last_acc && n < 20) begin step(); n++; end
      bus.redirect = 1'b1; bus.redirect_addr = 32'hC0;
      step();
      bus.redirect = 1'b0;
      repeat (4) step();
      chk("perf_entries", 32'(bus.inst_valid), 32'd1);
      bus.redirect = 1'b1; bus.redirect_addr = 32'h100;
      bus.imem_req_ready = 1'b0;
      step();
      bus.redirect = 1'b0;
      repeat (3) step();
      bus.inst_ready = 1'b1;
      repeat (5) step();
      bus.inst_ready = 1'b0;
      repeat (2) step();
      chk("perf_flush3", 32'(flush_count), 32'd3);
      chk("perf_stall5", 32'(stall_count), 32'd5);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
